// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter sitting beside DataMemory on the core's store/load path.
// Window: DATA (0x0), STATUS (0x4, {OVR, DONE, Busy}), DIV (0x8, clocks per bit).
module uart_tx_port #(
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0100,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Selected,
  output logic        TxSerial,
  output logic        Busy,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  localparam logic [15:0] DIV_RST = 16'(CLKS_PER_BIT);

  state_e      state_q, state_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] div_q, div_d;
  logic [15:0] fdiv_q, fdiv_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  idx_q, idx_d;
  logic        done_q, done_d;
  logic        ovr_q, ovr_d;

  logic        wr_data, wr_stat, wr_div, done_set;
  logic [15:0] eff_div;
  logic        unused_bits;

  // Upper store bits and the byte offset within a word carry no information here.
  assign unused_bits = ^{WriteData[31:16], Address[1:0]};

  assign Selected = (Address[31:4] == BASE_ADDR[31:4]) && (Address[3:2] != 2'b11);
  assign wr_data  = MemWrite && Selected && (Address[3:2] == 2'b00);
  assign wr_stat  = MemWrite && Selected && (Address[3:2] == 2'b01);
  assign wr_div   = MemWrite && Selected && (Address[3:2] == 2'b10);

  // Divisors below 2 would leave the baud counter no room to count; clamp them.
  assign eff_div = (div_q < 16'd2) ? 16'd2 : div_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      data_q  <= 8'h00;
      div_q   <= DIV_RST;
      fdiv_q  <= 16'd0;
      baud_q  <= 16'd0;
      idx_q   <= 3'd0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      div_q   <= div_d;
      fdiv_q  <= fdiv_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    div_d    = div_q;
    fdiv_d   = fdiv_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    done_d   = done_q;
    ovr_d    = ovr_q;
    done_set = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (wr_data) begin
          data_d  = WriteData[7:0];
          fdiv_d  = eff_div;
          baud_d  = eff_div - 16'd1;
          idx_d   = 3'd0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_q == 16'd0) begin
          baud_d  = fdiv_q - 16'd1;
          idx_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_DATA: begin
        if (baud_q == 16'd0) begin
          baud_d = fdiv_q - 16'd1;
          idx_d  = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_STOP: begin
        if (baud_q == 16'd0) begin
          state_d  = S_IDLE;
          done_set = 1'b1;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status clear is applied first so a same-edge set takes priority.
    if (wr_stat) begin
      done_d = 1'b0;
      ovr_d  = 1'b0;
    end
    if (wr_data && (state_q != S_IDLE)) ovr_d = 1'b1;
    if (done_set) done_d = 1'b1;
    if (wr_div) div_d = WriteData[15:0];
  end

  always_comb begin
    TxSerial = 1'b1;
    case (state_q)
      S_START: TxSerial = 1'b0;
      S_DATA:  TxSerial = data_q[idx_q];
      default: TxSerial = 1'b1;
    endcase
  end

  assign Busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

  always_comb begin
    ReadData = 32'd0;
    if (MemRead && Selected) begin
      case (Address[3:2])
        2'b00:   ReadData = {24'd0, data_q};
        2'b01:   ReadData = {29'd0, ovr_q, done_q, Busy};
        2'b10:   ReadData = {16'd0, div_q};
        default: ReadData = 32'd0;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_port.md
Name: uart_tx_port

Overview:
- Memory-mapped UART transmitter on the data-memory bus, downstream of the single-cycle MIPS core.
- Consumes the core's store path (ALU byte address, ReadData2 write data, MemWrite/MemRead) in parallel with DataMemory.
- A store to its window serialises one byte on TxSerial, 8N1.
- Status is readable by lw so software can poll busy/done.

Parameters:
- BASE_ADDR, 32'h1001_0100: byte address of the register window (3 words, offsets 0x0/0x4/0x8).
- CLKS_PER_BIT, 16: reset value of the divisor register (clock cycles per serial bit).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- Address  in  32  byte address from ALU result
- WriteData  in  32  store data (rt register)
- MemWrite  in  1  store strobe, one cycle per sw
- MemRead  in  1  load strobe
- ReadData  out  32  load data; 0 when not selected or MemRead=0
- Selected  out  1  Address falls in window; top level uses it to steer the load mux away from RAM
- TxSerial  out  1  serial line, idle high
- Busy  out  1  frame in progress

Behaviour:
- Reset (reset=0 at a rising edge): TxSerial=1, Busy=0, state IDLE, DATA reg=0, DONE=0, OVR=0, DIV=CLKS_PER_BIT, counters=0. Reset mid-frame aborts immediately; line returns high next cycle.
- Decode: Selected = (Address[31:4] == BASE_ADDR[31:4]) && Address[3:2] != 2'b11. Address[1:0] ignored (word access only).
- Registers:
  - 0x0 DATA: write = byte WriteData[7:0]; read = last accepted byte zero-extended.
  - 0x4 STATUS: read = {29'b0, OVR, DONE, Busy}; any write clears DONE and OVR.
  - 0x8 DIV: 16-bit R/W, WriteData[15:0]; read zero-extended.
- ReadData: combinational from Address; 0 when !MemRead or !Selected.
- Write DATA while IDLE: byte latched, DIV snapshotted to an internal frame divisor, state→START on the same edge; Busy=1 from the next cycle.
- Write DATA while Busy: byte discarded, DATA reg unchanged, OVR set.
- Effective divisor: a snapshot value of 0 or 1 is treated as 2.
- Bit timing: each bit lasts exactly D cycles (D = effective divisor). The baud counter loads D-1 on bit entry and advances the bit when it reaches 0.
- FSM:
  - IDLE: TxSerial=1.
  - START: TxSerial=0 for D cycles.
  - DATA: bits 0..7, LSB first, D cycles each; a 3-bit index wraps 7→exit.
  - STOP: TxSerial=1 for D cycles → IDLE.
- Frame timing: frame occupies exactly 10*D cycles from the first START cycle. Busy deasserts the cycle after the last STOP cycle, and DONE sets on that same edge.
- A DATA write in the first IDLE cycle after STOP is accepted (back-to-back frames, one idle-high cycle between them).
- Simultaneous STATUS write and DONE/OVR set on the same edge: set wins.
- DIV writes while Busy update the register only; the current frame keeps its snapshot.
- MemRead and MemWrite both high: write performed; read returns pre-write value.
- Writes outside the window are ignored. Offset 0xC is unmapped: not selected, no effect.

Test Plan:
- Reset with reset=0 for 2 cycles → TxSerial=1, Busy=0, lw 0x1001_0104 returns 0, lw 0x1001_0108 returns 16.
- sw 0x55 to 0x1001_0100 with DIV=16 → TxSerial pattern 0,1,0,1,0,1,0,1,0,1 each held 16 cycles; Busy high exactly 160 cycles; STATUS reads 0x2 afterwards.
- Second sw 0xA3 to DATA 20 cycles into a frame → frame bits unchanged (still 0x55), DATA reads 0x55, STATUS=0x5 while busy; sw 0 to STATUS after the frame → STATUS=0x0.
- sw 1 to DIV, then sw 0xFF to DATA → bits last 2 cycles, frame 20 cycles. Then sw 4 to DIV during a frame → current frame stays at 2-cycle bits, next frame uses 4 (40 cycles).
- reset asserted on cycle 50 of a 160-cycle frame → next cycle TxSerial=1, Busy=0, DONE=0, DIV=16; no stop bit emitted.
- lw from 0x1001_0200 and 0x1001_010C → Selected=0, ReadData=0; sw there → no frame starts, no flags change.
